// File: rtl/sqrt_16b_rescale.sv
// rtl/sqrt_16b_rescale.sv - iterative 16-bit integer square root with power-of-two rescale
//
// Takes the 16-bit operand from the upstream range scaler together with the
// number of divide-by-4 steps it applied, produces an 8-bit root one bit per
// cycle, then shifts the root left by that count to restore the magnitude.
//
// Ports:
//   clk_i    in   1  clock, rising edge
//   rst_i    in   1  synchronous active-high reset
//   start_i  in   1  request, accepted only in IDLE or DONE
//   data_i   in  16  scaled operand
//   shift_i  in   4  upstream 2-bit shift count, saturated to 8
//   busy_o   out  1  high while iterating or rescaling
//   done_o   out  1  one-cycle pulse, root_o/rem_o valid
//   root_o   out 16  floor(sqrt(data_i)) << min(shift_i, 8)
//   rem_o    out  9  data_i - floor(sqrt(data_i))^2, unscaled
module sqrt_16b_rescale (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] data_i,
  input  logic [3:0]  shift_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] root_o,
  output logic [8:0]  rem_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] x;
  logic [9:0]  rem;
  logic [7:0]  root;
  logic [3:0]  sh;
  logic [2:0]  cnt;

  logic        accept;
  logic [9:0]  r_next;
  logic [9:0]  trial;
  logic        fits;
  logic        rem_unused;

  assign accept = ((state == IDLE) || (state == DONE)) && start_i;

  // One digit of the root per cycle: bring down the next two operand bits
  // and try to subtract 4*root + 1. Before the last step the remainder is at
  // most 2*127, so only rem[7:0] needs to be carried into the window.
  assign r_next = {rem[7:0], x[15:14]};
  assign trial  = {root, 2'b01};
  assign fits   = (r_next >= trial);

  // The final remainder never exceeds 2*255, so the top bit stays clear.
  assign rem_unused = rem[9];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_i ? CALC : IDLE;
      CALC:    state_nxt = (cnt == 3'd0) ? SCALE : CALC;
      SCALE:   state_nxt = DONE;
      DONE:    state_nxt = start_i ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state)
      CALC:    busy_o = 1'b1;
      SCALE:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x      <= '0;
      rem    <= '0;
      root   <= '0;
      sh     <= '0;
      cnt    <= '0;
      root_o <= '0;
      rem_o  <= '0;
    end else if (accept) begin
      x    <= data_i;
      sh   <= (shift_i > 4'd8) ? 4'd8 : shift_i;
      rem  <= '0;
      root <= '0;
      cnt  <= 3'd7;
    end else begin
      case (state)
        CALC: begin
          x <= {x[13:0], 2'b00};
          if (fits) begin
            rem  <= r_next - trial;
            root <= {root[6:0], 1'b1};
          end else begin
            rem  <= r_next;
            root <= {root[6:0], 1'b0};
          end
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end
        end
        SCALE: begin
          // sh <= 8 keeps the 8-bit root inside 16 bits.
          root_o <= {8'h00, root} << sh;
          rem_o  <= rem[8:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_16b_rescale.sv
// tb/tb_sqrt_16b_rescale.sv - randomized self-checking bench for sqrt_16b_rescale
module tb_sqrt_16b_rescale;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic [3:0]  shift;
  logic        busy;
  logic        done;
  logic [15:0] root;
  logic [8:0]  rem;

  int tests;
  int fails;
  int cyc;

  sqrt_16b_rescale dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .data_i  (data),
    .shift_i (shift),
    .busy_o  (busy),
    .done_o  (done),
    .root_o  (root),
    .rem_o   (rem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference arithmetic
  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int sat_shift(input int s);
    return (s > 8) ? 8 : s;
  endfunction

  // Behavioural model: a request is accepted when idle/finished, is busy for
  // nine cycles, then shows its result with a single done cycle.
  int          m_phase;   // 0 idle, 1 busy, 2 done
  int          m_age;
  logic [15:0] m_root;
  logic [8:0]  m_rem;
  logic [15:0] p_root;
  logic [8:0]  p_rem;

  initial begin
    m_phase = 0;
    m_age   = 0;
    m_root  = '0;
    m_rem   = '0;
    p_root  = '0;
    p_rem   = '0;
    cyc     = 0;
  end

  always @(posedge clk) begin
    int r;
    cyc++;
    if (rst) begin
      m_phase = 0;
      m_root  = '0;
      m_rem   = '0;
    end else if (m_phase == 1) begin
      m_age++;
      if (m_age == 9) begin
        m_phase = 2;
        m_root  = p_root;
        m_rem   = p_rem;
      end
    end else if (start) begin
      r       = isqrt(int'(data));
      p_root  = 16'(r << sat_shift(int'(shift)));
      p_rem   = 9'(int'(data) - r * r);
      m_phase = 1;
      m_age   = 0;
    end else begin
      m_phase = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  logic prev_done;
  initial prev_done = 1'b0;

  always @(negedge clk) begin
    tests++;
    if ({busy, done, root, rem} !== {(m_phase == 1), (m_phase == 2), m_root, m_rem}) begin
      fails++;
      $display("FAIL model: busy=%b done=%b root=%0d rem=%0d, expected busy=%b done=%b root=%0d rem=%0d (cycle %0d)",
               busy, done, root, rem, (m_phase == 1), (m_phase == 2), m_root, m_rem, cyc);
    end
    tests++;
    if (prev_done && done) begin
      fails++;
      $display("FAIL done_twice: got done high on two consecutive cycles, expected single pulse (cycle %0d)", cyc);
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits for the done cycle (sampled mid-cycle); reports busy cycles seen.
  task automatic wait_done(output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done within 40 cycles, expected done pulse");
    end
  endtask

  task automatic run_lit(input logic [15:0] d, input logic [3:0] s,
                         input int exp_root, input int exp_rem, input string name);
    int  bc;
    bit  ok;
    data  = d;
    shift = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    data  = $urandom;
    shift = 4'($urandom);
    wait_done(bc, ok);
    check({name, "_root"}, int'(root), exp_root);
    check({name, "_rem"}, int'(rem), exp_rem);
    check({name, "_busy_cycles"}, bc, 9);
    tick();
  endtask

  initial begin
    int  bc;
    bit  ok;
    int  t_first;
    int  seen_done;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    shift = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_root", int'(root), 0);
    check("reset_rem", int'(rem), 0);
    tick();
    rst = 1'b0;
    tick();

    run_lit(16'h0000, 4'd0,  0,      0,   "zero");
    run_lit(16'hffff, 4'd0,  16'h00ff, 510, "max");
    run_lit(16'h0010, 4'd0,  4,      0,   "sixteen");
    run_lit(16'h4000, 4'd3,  1024,   0,   "shift3");
    run_lit(16'hffff, 4'd12, 16'hff00, 510, "shift_sat");

    // Start during CALC is ignored; start held through DONE is accepted.
    data  = 16'h0019;
    shift = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    data  = 16'h0064;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    wait_done(bc, ok);
    t_first = cyc;
    check("ignore_root", int'(root), 5);
    check("ignore_rem", int'(rem), 0);
    tick();
    start = 1'b0;
    wait_done(bc, ok);
    check("b2b_root", int'(root), 10);
    check("b2b_gap", cyc - t_first, 10);
    tick();

    // Reset mid-CALC together with start
    data  = 16'h1234;
    shift = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_root", int'(root), 0);
    check("rst_rem", int'(rem), 0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("rst_no_done", seen_done, 0);
    tick();
    run_lit(16'h0051, 4'd0, 9, 0, "after_rst");

    // Random sweep, with ignored start pulses while busy
    for (int n = 0; n < 1000; n++) begin
      data  = 16'($urandom);
      shift = 4'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) tick();
        data  = 16'($urandom);
        shift = 4'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_done(bc, ok);
      if (!ok) break;
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
